// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
//
// Parallel-in, serial-out transmitter for the enable-strobed serial link.
// A WIDTH-bit word is accepted through a ready/load handshake and then
// shifted out MSB first, one bit per enable strobe. A receiver that shifts
// serial_out into its LSB on the same strobes ends up holding the word.
//
// Build option:
//   PISO_PARITY_EN - when defined, the even-parity bit of the loaded word is
//                    sent as one extra bit after the data bits, so a
//                    transfer takes WIDTH+1 strobes instead of WIDTH.
//                    The port list is the same in both builds.
//
// Parameters:
//   WIDTH      data word width in bits (2 or more)
//
// Ports:
//   clk        system clock, rising-edge active
//   resetn     asynchronous active-low reset
//   load       request to accept data_in (only honoured while ready=1)
//   data_in    parallel word, captured on the accepted load edge
//   enable     shift strobe; each high cycle while busy consumes one bit
//   serial_out current serial bit, valid while busy, 0 otherwise
//   ready      high when idle and able to accept a load
//   busy       high while a word (plus parity, if built in) is being sent
//   done       one-cycle pulse after the last bit has been consumed
// ---------------------------------------------------------------------------
module piso_serializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             enable,
    output logic             serial_out,
    output logic             ready,
    output logic             busy,
    output logic             done
);

    // Counter is wide enough to hold WIDTH, the highest bit index reached
    // when the parity bit is appended.
    localparam int CNT_W = $clog2(WIDTH + 1);

`ifdef PISO_PARITY_EN
    localparam int LAST_IDX = WIDTH;
`else
    localparam int LAST_IDX = WIDTH - 1;
`endif

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LAST_IDX);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             done_q,  done_d;
`ifdef PISO_PARITY_EN
    logic             parity_q, parity_d;
`endif

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; an unassigned path would infer a latch.
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
`ifdef PISO_PARITY_EN
        parity_d = parity_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // enable is deliberately ignored here: the load cycle never
                // consumes a bit.
                if (load) begin
                    shift_d = data_in;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
`ifdef PISO_PARITY_EN
                    parity_d = ^data_in;
`endif
                end
            end

            ST_SHIFT: begin
                // load is ignored while busy; data_in is not sampled.
                if (enable) begin
                    shift_d = {shift_q[WIDTH-2:0], 1'b0};
                    if (cnt_q == LAST) begin
                        // Clearing instead of incrementing keeps the counter
                        // from ever wrapping past its range.
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

`ifdef PISO_PARITY_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // serial_out is combinational from the register so the first bit is
    // already valid in the first SHIFT cycle; it is forced low when idle.
    logic serial_bit;

`ifdef PISO_PARITY_EN
    // After WIDTH shifts the register is all zeros; the parity bit is
    // selected in its place for the final strobe.
    assign serial_bit = (cnt_q == LAST) ? parity_q : shift_q[WIDTH-1];
`else
    assign serial_bit = shift_q[WIDTH-1];
`endif

    assign serial_out = (state_q == ST_SHIFT) & serial_bit;
    assign ready      = (state_q == ST_IDLE);
    assign busy       = (state_q == ST_SHIFT);
    assign done       = done_q;

endmodule
